call_request_registry: RTL and testbench

CALL_REQUEST_REGISTRY -- requirements
Module: call_request_registry

---
 rtl/call_request_registry.sv | 112 +++++++++++
 tb/tb_call_request_registry.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/call_request_registry.sv
// Latches hall up/down and in-car floor calls for a 4-floor elevator until serviced at an open door.
// Optional per-button debounce is enabled by defining CALL_DEBOUNCE_EN.
module call_request_registry #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] up_btn,
    input  logic [3:0] down_btn,
    input  logic [3:0] car_btn,
    input  logic [3:0] cur_floor,
    input  logic       door_state,
    input  logic       over_weight,
    output logic [3:0] move_up_call,
    output logic [3:0] move_down_call,
    output logic [3:0] req_floor,
    output logic       call_pending
);

    // Bit layout of every 12-bit vector: [3:0] up, [7:4] down, [11:8] car.
    localparam logic [11:0] VALID_MASK = 12'hFE7;

    logic [11:0] raw_btn;
    logic [11:0] sync_meta;
    logic [11:0] sync_out;
    logic [11:0] accepted;
    logic [11:0] accepted_prev;
    logic [11:0] press_q;
    logic [11:0] pending_q;
    logic [11:0] pending_next;
    logic [11:0] press_eff;
    logic [11:0] service_clear;
    logic        floor_one_hot;

    assign raw_btn = {car_btn, down_btn, up_btn};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= '0;
            sync_out  <= '0;
        end else begin
            sync_meta <= raw_btn;
            sync_out  <= sync_meta;
        end
    end

`ifdef CALL_DEBOUNCE_EN
    logic [3:0]  deb_cnt [12];
    logic [11:0] deb_level;

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_level <= '0;
            for (int i = 0; i < 12; i++) deb_cnt[i] <= 4'd0;
        end else begin
            for (int i = 0; i < 12; i++) begin
                if (sync_out[i] != deb_level[i]) begin
                    if (deb_cnt[i] == 4'(DEBOUNCE_CYCLES - 1)) begin
                        deb_level[i] <= sync_out[i];
                        deb_cnt[i]   <= 4'd0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 4'd1;
                    end
                end else begin
                    deb_cnt[i] <= 4'd0;
                end
            end
        end
    end

    assign accepted = deb_level;
`else
    assign accepted = sync_out;
`endif

    // Rising edge of the accepted level is captured as a one-cycle press pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            accepted_prev <= '0;
            press_q       <= '0;
        end else begin
            accepted_prev <= accepted;
            press_q       <= accepted & ~accepted_prev;
        end
    end

    always_comb begin
        press_eff     = press_q & VALID_MASK;
        service_clear = '0;
        floor_one_hot = (cur_floor != 4'd0) && ((cur_floor & (cur_floor - 4'd1)) == 4'd0);
        if (over_weight) press_eff[11:8] = 4'd0;
        if (door_state && floor_one_hot) service_clear = {cur_floor, cur_floor, cur_floor};
        // Clear has priority over a press landing on the same bit.
        pending_next = (pending_q | press_eff) & ~service_clear;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q    <= '0;
            call_pending <= 1'b0;
        end else begin
            pending_q    <= pending_next;
            call_pending <= |pending_next;
        end
    end

    assign move_up_call   = pending_q[3:0];
    assign move_down_call = pending_q[7:4];
    assign req_floor      = pending_q[11:8];

endmodule

// File: tb/tb_call_request_registry.sv
// Self-checking bench for call_request_registry: directed scenarios plus random buttons against a delay-line model.
// Honours CALL_DEBOUNCE_EN the same way as the design.
module tb_call_request_registry;

    localparam int DEB = 4;
`ifdef CALL_DEBOUNCE_EN
    localparam int LAT = 3 + DEB;
`else
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] up_btn, down_btn, car_btn, cur_floor;
    logic       door_state, over_weight;
    logic [3:0] move_up_call, move_down_call, req_floor;
    logic       call_pending;

    int checks = 0;
    int fails  = 0;

    // Model state: raw samples and accepted levels from previous edges, plus pending calls.
    logic [11:0] m_raw1, m_raw2;
    logic [11:0] m_a1, m_a2, m_a3;
    logic [11:0] m_pend;
    int          m_cnt [12];

    always #5 clk = ~clk;

    call_request_registry #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .rst(rst),
        .up_btn(up_btn), .down_btn(down_btn), .car_btn(car_btn),
        .cur_floor(cur_floor), .door_state(door_state), .over_weight(over_weight),
        .move_up_call(move_up_call), .move_down_call(move_down_call),
        .req_floor(req_floor), .call_pending(call_pending)
    );

    task automatic checkOutput(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Accepted level A(e): press lands at edge e when A(e-2)=1 and A(e-3)=0.
    task automatic modelEdge();
        logic [11:0] a_new, press, clr;
        if (rst) begin
            m_raw1 = '0; m_raw2 = '0;
            m_a1 = '0; m_a2 = '0; m_a3 = '0;
            m_pend = '0;
            for (int i = 0; i < 12; i++) m_cnt[i] = 0;
        end else begin
`ifdef CALL_DEBOUNCE_EN
            a_new = m_a1;
            for (int i = 0; i < 12; i++) begin
                if (m_raw2[i] != m_a1[i]) begin
                    m_cnt[i]++;
                    if (m_cnt[i] == DEB) begin
                        a_new[i] = m_raw2[i];
                        m_cnt[i] = 0;
                    end
                end else begin
                    m_cnt[i] = 0;
                end
            end
`else
            a_new = m_raw1;
`endif
            press = m_a2 & ~m_a3;
            press[3] = 1'b0;
            press[4] = 1'b0;
            if (over_weight) press[11:8] = 4'd0;
            clr = '0;
            if (door_state && $countones(cur_floor) == 1) clr = {cur_floor, cur_floor, cur_floor};
            m_pend = (m_pend | press) & ~clr;
            m_a3 = m_a2; m_a2 = m_a1; m_a1 = a_new;
            m_raw2 = m_raw1; m_raw1 = {car_btn, down_btn, up_btn};
        end
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge clk);
            modelEdge();
            #1;
            checkOutput("model_up",   move_up_call,   m_pend[3:0]);
            checkOutput("model_down", move_down_call, m_pend[7:4]);
            checkOutput("model_car",  req_floor,      m_pend[11:8]);
            checkOutput("model_any",  {3'b000, call_pending}, {3'b000, |m_pend});
        end
    endtask

    task automatic resetAll();
        up_btn = 4'd0; down_btn = 4'd0; car_btn = 4'd0;
        cur_floor = 4'd0; door_state = 1'b0; over_weight = 1'b0;
        rst = 1'b1;
        applyStimulus(1);
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 12; i++) m_cnt[i] = 0;
        m_raw1 = '0; m_raw2 = '0; m_a1 = '0; m_a2 = '0; m_a3 = '0; m_pend = '0;
        #2;
        resetAll();
        checkOutput("reset_any", {3'b000, call_pending}, 4'd0);
        checkOutput("reset_up",  move_up_call, 4'd0);

        // Held up call latches once after the pipeline latency and never re-latches while held.
        up_btn = 4'b0100;
        applyStimulus(LAT);
        checkOutput("up_early", move_up_call, 4'd0);
        applyStimulus(1);
        checkOutput("up_latched", move_up_call, 4'b0100);
        checkOutput("up_pending", {3'b000, call_pending}, 4'd1);
        door_state = 1'b1; cur_floor = 4'b0100;
        applyStimulus(1);
        checkOutput("up_cleared", move_up_call, 4'd0);
        door_state = 1'b0; cur_floor = 4'd0;
        applyStimulus(LAT + 3);
        checkOutput("up_no_relatch", move_up_call, 4'd0);
        up_btn = 4'd0;
        applyStimulus(2);

        // Nonexistent directions at the end floors are ignored.
        up_btn = 4'b1000; down_btn = 4'b0001;
        applyStimulus(LAT + 3);
        checkOutput("top_up_ignored",  move_up_call, 4'd0);
        checkOutput("bot_dn_ignored",  move_down_call, 4'd0);
        checkOutput("end_floor_any",   {3'b000, call_pending}, 4'd0);
        up_btn = 4'd0; down_btn = 4'd0;
        applyStimulus(2);

        // Overload blocks new car calls but keeps existing ones.
        car_btn = 4'b0100;
        applyStimulus(LAT + 1);
        checkOutput("car_latched", req_floor, 4'b0100);
        car_btn = 4'd0;
        applyStimulus(2);
        over_weight = 1'b1; car_btn = 4'b0001;
        applyStimulus(LAT + 3);
        checkOutput("overweight_block", req_floor, 4'b0100);
        car_btn = 4'd0;
        applyStimulus(LAT + 1);
        over_weight = 1'b0;

        // Service clear at floor 3 while an up call at floor 1 lands on the same edge.
        down_btn = 4'b1000; car_btn = 4'b1000;
        applyStimulus(1);
        down_btn = 4'd0; car_btn = 4'd0;
        applyStimulus(LAT);
        checkOutput("f3_down_set", move_down_call, 4'b1000);
        checkOutput("f3_car_set",  req_floor, 4'b1100);
        up_btn = 4'b0010;
        applyStimulus(LAT);
        door_state = 1'b1; cur_floor = 4'b1000;
        applyStimulus(1);
        checkOutput("f3_down_clr", move_down_call, 4'd0);
        checkOutput("f3_car_clr",  req_floor, 4'b0100);
        checkOutput("f1_up_latch", move_up_call, 4'b0010);
        door_state = 1'b0; cur_floor = 4'd0; up_btn = 4'd0;
        applyStimulus(2);

        // Non-one-hot floor with door open performs no clear.
        door_state = 1'b1; cur_floor = 4'b0110;
        applyStimulus(2);
        checkOutput("multi_hot_keep", req_floor, 4'b0100);
        door_state = 1'b0; cur_floor = 4'd0;

        // Reset while a button is held, then the held button re-latches.
        up_btn = 4'b0100;
        applyStimulus(LAT + 1);
        rst = 1'b1;
        applyStimulus(1);
        rst = 1'b0;
        checkOutput("rst_up",  move_up_call, 4'd0);
        checkOutput("rst_car", req_floor, 4'd0);
        checkOutput("rst_any", {3'b000, call_pending}, 4'd0);
        applyStimulus(LAT);
        checkOutput("relatch_early", move_up_call, 4'd0);
        applyStimulus(1);
        checkOutput("relatch", move_up_call, 4'b0100);
        up_btn = 4'd0;
        resetAll();

`ifdef CALL_DEBOUNCE_EN
        // Short glitch is rejected; a long pulse is accepted after the debounce delay.
        car_btn = 4'b0010;
        applyStimulus(3);
        car_btn = 4'd0;
        applyStimulus(DEB + 6);
        checkOutput("glitch_reject", req_floor, 4'd0);
        car_btn = 4'b0010;
        applyStimulus(6);
        car_btn = 4'd0;
        applyStimulus(1);
        checkOutput("pulse_early", req_floor, 4'd0);
        applyStimulus(1);
        checkOutput("pulse_accept", req_floor, 4'b0010);
        resetAll();
`endif

        // Random phase: buttons toggle occasionally so holds and short pulses both occur.
        for (int c = 0; c < 800; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 7) == 0) up_btn[b]   = ~up_btn[b];
                if ($urandom_range(0, 7) == 0) down_btn[b] = ~down_btn[b];
                if ($urandom_range(0, 7) == 0) car_btn[b]  = ~car_btn[b];
            end
            door_state  = ($urandom_range(0, 3) == 0);
            cur_floor   = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15))
                                                      : 4'(1 << $urandom_range(0, 3));
            over_weight = ($urandom_range(0, 7) == 0);
            rst         = ($urandom_range(0, 99) == 0);
            applyStimulus(1);
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
